// File: rtl/gpu_mem_controller.sv
// gpu_mem_controller
//   Shared data-memory responder for the GPU cores' load/store paths. It owns
//   the word array `main_mem`. Requests are granted round-robin, one at a time,
//   and each grant is answered after a fixed MEM_LATENCY cycles.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset (main_mem is not cleared)
//   req_valid   per-core request valid
//   req_we      per-core write enable (1 = store, 0 = load)
//   req_addr    per-core word address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   per-core store data, packed the same way
//   req_ready   one-hot acceptance strobe (combinational, IDLE only)
//   resp_valid  one-hot, one-cycle response strobe
//   resp_data   load data or store echo; holds its value between responses
module gpu_mem_controller #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_CORES-1:0]             req_valid,
  input  logic [NUM_CORES-1:0]             req_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_CORES-1:0]             req_ready,
  output logic [NUM_CORES-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data
);

  localparam int CW = (NUM_CORES > 1)   ? $clog2(NUM_CORES)   : 1;
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;  // holds MEM_LATENCY-1
  localparam int MW = (MEM_DEPTH > 1)   ? $clog2(MEM_DEPTH)   : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  logic [DATA_WIDTH-1:0] main_mem [MEM_DEPTH];

  // per-core views of the packed request buses
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_wdata;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign core_addr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign core_wdata[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  // round-robin search starting at rr_q
  logic          gnt_any;
  logic [CW-1:0] gnt_idx;

  always_comb begin
    int j;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = (int'(rr_q) + k) % NUM_CORES;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(j);
      end
    end
  end

  logic hs;
  assign hs        = (state_q == IDLE) && reset_n && gnt_any;
  assign req_ready = hs ? (NUM_CORES'(1) << gnt_idx) : '0;

  logic resp_cyc;
  assign resp_cyc   = (state_q == BUSY) && (cnt_q == '0);
  assign resp_valid = (resp_cyc && reset_n) ? (NUM_CORES'(1) << gnt_q) : '0;
  assign resp_data  = resp_data_q;

  // resp_data is loaded at the edge that opens the response cycle, so a
  // MEM_LATENCY of 1 loads straight from the request being accepted
  logic ent_resp;
  logic rd_in_range, wr_in_range;
  logic mem_we;

  assign rd_in_range = ({1'b0, addr_d} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, addr_q} < DEPTH_LIM);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    ent_resp    = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          gnt_d   = gnt_idx;
          we_d    = req_we[gnt_idx];
          addr_d  = core_addr[gnt_idx];
          wdata_d = core_wdata[gnt_idx];
          rr_d    = (gnt_idx == CW'(NUM_CORES-1)) ? '0 : gnt_idx + CW'(1);
          cnt_d   = LW'(MEM_LATENCY-1);
          state_d = BUSY;
          ent_resp = (MEM_LATENCY == 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // store commits at the edge ending the response cycle
          mem_we  = we_q && wr_in_range;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q - LW'(1);
          ent_resp = (cnt_q == LW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    if (ent_resp) begin
      if (we_d)             resp_data_d = wdata_d;
      else if (rd_in_range) resp_data_d = main_mem[addr_d[MW-1:0]];
      else                  resp_data_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  // no reset: preloaded contents survive; reset also blocks an uncommitted store
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) main_mem[addr_q[MW-1:0]] <= wdata_q;
  end

endmodule

// File: tb/tb_gpu_mem_controller.sv
module tb_gpu_mem_controller;
  localparam int NC = 4, AW = 8, DW = 8, MD = 64, LAT = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC-1:0]     req_valid = '0, req_we = '0;
  logic [NC*AW-1:0]  req_addr = '0;
  logic [NC*DW-1:0]  req_wdata = '0;
  logic [NC-1:0]     req_ready, resp_valid;
  logic [DW-1:0]     resp_data;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] mdl_mem [MD];

  always #5 clock = ~clock;

  gpu_mem_controller #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MEM_DEPTH(MD), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs change at posedge+1, outputs are sampled at posedge+3
  task automatic nxt(); @(posedge clock); #1; endtask

  function automatic logic [7:0] pat(input int i); return 8'(i * 7 + 3); endfunction

  function automatic int oh2idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int c, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_valid[c] = v; req_we[c] = we;
    req_addr[c*AW +: AW] = a; req_wdata[c*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    reset_n = 1'b0;
    nxt(); nxt();
    #2;
    chk("reset req_ready", req_ready, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_data", resp_data, 0);
    reset_n = 1'b1;
  endtask

  // single transaction on an idle block: ready at T, response only at T+LAT
  task automatic do_txn(input int c, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input string nm, output logic [DW-1:0] rd);
    set_req(c, 1'b1, we, a, wd);
    #2;
    chk({nm, " ready"}, req_ready, 32'(1) << c);
    nxt();
    set_req(c, 1'b0, 1'b0, '0, '0);
    rd = '0;
    for (int k = 1; k <= LAT; k++) begin
      #2;
      if (k == LAT) begin
        chk({nm, " resp_valid"}, resp_valid, 32'(1) << c);
        rd = resp_data;
      end else begin
        chk({nm, " early resp"}, resp_valid, 0);
      end
      nxt();
    end
    if (we && a < MD) mdl_mem[a] = wd;
  endtask

  // every core in mask loads the address equal to its own index
  task automatic contend(input logic [NC-1:0] mask, input int n,
                         input int o0, input int o1, input int o2, input int o3,
                         input string nm);
    int ord[4]; int gord[4]; int rcore[4]; int rcyc[4]; logic [DW-1:0] rdat[4];
    int gcnt, rcnt, drop;
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    gcnt = 0; rcnt = 0;
    for (int c = 0; c < NC; c++) if (mask[c]) set_req(c, 1'b1, 1'b0, 8'(c), '0);
    for (int cyc = 0; cyc < 40 && rcnt < n; cyc++) begin
      #2;
      drop = -1;
      if (req_ready != 0 && gcnt < 4) begin
        gord[gcnt] = oh2idx(req_ready); drop = gord[gcnt]; gcnt++;
      end
      if (resp_valid != 0 && rcnt < 4) begin
        rcore[rcnt] = oh2idx(resp_valid); rcyc[rcnt] = cyc; rdat[rcnt] = resp_data; rcnt++;
      end
      nxt();
      if (drop >= 0) set_req(drop, 1'b0, 1'b0, '0, '0);
    end
    req_valid = '0;
    chk({nm, " responses"}, rcnt, n);
    for (int k = 0; k < n && k < rcnt; k++) begin
      chk($sformatf("%s grant%0d", nm, k), gord[k], ord[k]);
      chk($sformatf("%s resp core%0d", nm, k), rcore[k], ord[k]);
      chk($sformatf("%s data%0d", nm, k), rdat[k], pat(ord[k]));
      if (k > 0) chk($sformatf("%s spacing%0d", nm, k), rcyc[k] - rcyc[k-1], LAT + 1);
    end
  endtask

  typedef struct {
    int          core;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    int         cyc;
    int         core;
    logic [7:0] data;
  } rsp_t;

  initial begin
    vec_t tbl [16];
    logic [DW-1:0] rd;
    rsp_t q[$];
    rsp_t r;
    logic         pv [NC];
    logic         pwe [NC];
    logic [7:0]   pad [NC];
    logic [7:0]   pwd [NC];
    int rr, free_at, g;
    logic [NC-1:0] exp_rdy, exp_rv;
    logic [7:0] last, exp_d;

    tbl[0]  = '{2, 1'b1, 8'd5,   8'h2A, 8'h2A};
    tbl[1]  = '{0, 1'b0, 8'd5,   8'h00, 8'h2A};
    tbl[2]  = '{1, 1'b1, 8'd48,  8'h7F, 8'h7F};
    tbl[3]  = '{1, 1'b0, 8'd48,  8'h00, 8'h7F};
    tbl[4]  = '{3, 1'b1, 8'd6,   8'h66, 8'h66};
    tbl[5]  = '{0, 1'b1, 8'd70,  8'h11, 8'h11};
    tbl[6]  = '{0, 1'b0, 8'd70,  8'h00, 8'h00};
    tbl[7]  = '{2, 1'b0, 8'd6,   8'h00, 8'h66};
    tbl[8]  = '{3, 1'b1, 8'd63,  8'hC3, 8'hC3};
    tbl[9]  = '{1, 1'b1, 8'd255, 8'h55, 8'h55};
    tbl[10] = '{1, 1'b0, 8'd255, 8'h00, 8'h00};
    tbl[11] = '{2, 1'b0, 8'd63,  8'h00, 8'hC3};
    tbl[12] = '{0, 1'b1, 8'd64,  8'hEE, 8'hEE};
    tbl[13] = '{3, 1'b0, 8'd0,   8'h00, 8'h03};
    tbl[14] = '{0, 1'b0, 8'd64,  8'h00, 8'h00};
    tbl[15] = '{1, 1'b1, 8'd10,  8'h10, 8'h10};

    do_reset();

    // fill every word through the store path with a known pattern
    for (int i = 0; i < MD; i++) begin
      do_txn(i % NC, 1'b1, 8'(i), pat(i), "preload", rd);
      chk($sformatf("preload ack%0d", i), rd, pat(i));
    end

    for (int i = 0; i < 16; i++) begin
      do_txn(tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wdata, $sformatf("vec%0d", i), rd);
      chk($sformatf("vec%0d data", i), rd, tbl[i].exp);
    end

    // reset during a store: no response, store not committed
    set_req(0, 1'b1, 1'b1, 8'd10, 8'hAA);
    #2;
    chk("rstmid ready", req_ready, 1);
    nxt();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 8'd3, '0);
    reset_n = 1'b0;
    #2;
    chk("rstmid resp T+1", resp_valid, 0);
    nxt();
    #2;
    chk("rstmid resp T+2", resp_valid, 0);
    chk("rstmid data", resp_data, 0);
    chk("rstmid ready gated", req_ready, 0);
    nxt();
    set_req(1, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("rstmid quiet", resp_valid, 0);
      nxt();
    end
    do_txn(2, 1'b0, 8'd10, '0, "rstmid reload", rd);
    chk("rstmid mem kept", rd, 8'h10);

    // all four cores at once from reset
    do_reset();
    contend(4'b1111, 4, 0, 1, 2, 3, "rr4");

    // after a core 2 grant, cores 0 and 3 together: 3 wins first
    do_reset();
    do_txn(2, 1'b0, 8'd2, '0, "wrap pre", rd);
    chk("wrap pre data", rd, pat(2));
    contend(4'b1001, 2, 3, 0, 0, 0, "wrap");

    // randomized traffic against a transaction-level model
    do_reset();
    rr = 0; free_at = 0; last = '0;
    for (int c = 0; c < NC; c++) begin pv[c] = 0; pwe[c] = 0; pad[c] = 0; pwd[c] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (!pv[c] && ($urandom % 3) == 0) begin
          pv[c] = 1; pwe[c] = 1'($urandom); pad[c] = 8'($urandom_range(0, 79));
          pwd[c] = 8'($urandom);
        end else if (pv[c] && ($urandom % 16) == 0) begin
          pv[c] = 0;
        end
        set_req(c, pv[c], pwe[c], pad[c], pwd[c]);
      end
      #2;
      exp_rdy = '0; g = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < NC; k++)
          if (g < 0 && pv[(rr + k) % NC]) g = (rr + k) % NC;
        if (g >= 0) exp_rdy = NC'(1) << g;
      end
      chk("rand ready", req_ready, exp_rdy);
      exp_rv = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        r = q.pop_front();
        exp_rv = NC'(1) << r.core;
        last = r.data;
      end
      chk("rand resp_valid", resp_valid, exp_rv);
      chk("rand resp_data", resp_data, last);
      if (g >= 0) begin
        if (pwe[g]) begin
          exp_d = pwd[g];
          if (pad[g] < MD) mdl_mem[pad[g]] = pwd[g];
        end else begin
          exp_d = (pad[g] < MD) ? mdl_mem[pad[g]] : 8'h00;
        end
        q.push_back('{cyc + LAT, g, exp_d});
        rr = (g + 1) % NC;
        free_at = cyc + LAT + 1;
        pv[g] = 0;
      end
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
